// File: rtl/pipe_scroller.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_scroller
//  Purpose  : Scrolls the single on-screen pipe pair once per frame, respawns
//             it at the right edge with a pseudo-random gap height, drives the
//             pipe-collision checker and tracks score / game-over state.
//  Option   : PIPE_SPEEDUP_EN - when defined, scroll speed rises by one pixel
//             per frame (capped at 4) each time the score reaches a multiple
//             of 8. When undefined, speed is the constant SPEED.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_scroller #(
  parameter int SCREEN_W = 160,
  parameter int PIPE_W   = 12,
  parameter int GAP_H    = 40,
  parameter int Y_MIN    = 8,
  parameter int SPEED    = 1,
  parameter int Y_INIT   = 40
) (
  input  logic       clk,
  input  logic       resetLow,
  input  logic       start,
  input  logic       frameTick,
  input  logic [7:0] xBird,
  input  logic       collisionHappen,
  output logic       evaluateCollision,
  output logic       collisionClearLow,
  output logic [7:0] xPipe,
  output logic [6:0] yPipe,
  output logic [7:0] height,
  output logic [4:0] width,
  output logic [7:0] score,
  output logic       running,
  output logic       gameOver
);

  localparam logic [7:0] X_SPAWN  = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_MIN_V  = 7'(Y_MIN);
  localparam logic [6:0] Y_INIT_V = 7'(Y_INIT);
  localparam logic [8:0] PIPE_W_9 = 9'(PIPE_W);
  localparam logic [2:0] SPEED_V  = 3'(SPEED);
  localparam logic [2:0] SPEED_MAX = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MOVE  = 3'd1,
    S_EVAL  = 3'd2,
    S_CHECK = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;

  // control strobes decoded from the FSM
  logic       restart;     // load start-of-game values
  logic       advance;     // frame tick accepted: move or respawn the pipe
  logic       decide;      // CHECK with no collision: scoring opportunity

  logic       scored;      // current pipe already counted
  logic [7:0] lfsr;
  logic       lfsr_fb;
  logic [2:0] step;        // effective pixels per frame
  logic       respawn;
  logic [8:0] pipe_right;
  logic       passed;
  logic       score_inc;
  logic [7:0] score_next;

  // geometry handed to the checker never changes
  assign height = 8'(GAP_H);
  assign width  = 5'(PIPE_W);

  // Fibonacci feedback for taps 8,6,5,4 (bits 7,5,4,3)
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // a position below the step would wrap through 0, so it respawns instead
  assign respawn    = (xPipe < {5'd0, step});
  // 9-bit so a pipe near the right edge cannot alias to a small value
  assign pipe_right = {1'b0, xPipe} + PIPE_W_9;
  assign passed     = !scored && (pipe_right < {1'b0, xBird});
  assign score_inc  = decide && passed;
  assign score_next = (score == 8'hFF) ? score : score + 8'd1;

  // state register
  always_ff @(posedge clk or negedge resetLow) begin
    if (!resetLow) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state and Moore/start-qualified outputs
  always_comb begin
    state_next        = state;
    evaluateCollision = 1'b0;
    collisionClearLow = 1'b1;
    running           = 1'b0;
    gameOver          = 1'b0;
    restart           = 1'b0;
    advance           = 1'b0;
    decide            = 1'b0;
    case (state)
      S_IDLE: begin
        // start has priority over a coincident frame tick, which is dropped
        if (start) begin
          collisionClearLow = 1'b0;
          restart           = 1'b1;
          state_next        = S_MOVE;
        end
      end
      S_MOVE: begin
        running = 1'b1;
        if (frameTick) begin
          advance    = 1'b1;
          state_next = S_EVAL;
        end
      end
      S_EVAL: begin
        running           = 1'b1;
        evaluateCollision = 1'b1;
        state_next        = S_CHECK;
      end
      S_CHECK: begin
        running = 1'b1;
        if (collisionHappen) begin
          state_next = S_OVER;
        end else begin
          decide     = 1'b1;
          state_next = S_MOVE;
        end
      end
      S_OVER: begin
        gameOver = 1'b1;
        if (start) begin
          collisionClearLow = 1'b0;
          restart           = 1'b1;
          state_next        = S_MOVE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // free-running gap-position generator; seed is nonzero so it never locks up
  always_ff @(posedge clk or negedge resetLow) begin
    if (!resetLow) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end

  // pipe position, gap height and the per-pipe scored flag
  always_ff @(posedge clk or negedge resetLow) begin
    if (!resetLow) begin
      xPipe  <= X_SPAWN;
      yPipe  <= Y_INIT_V;
      scored <= 1'b0;
    end else if (restart) begin
      xPipe  <= X_SPAWN;
      yPipe  <= Y_INIT_V;
      scored <= 1'b0;
    end else if (advance) begin
      if (respawn) begin
        xPipe  <= X_SPAWN;
        yPipe  <= Y_MIN_V + {1'b0, lfsr[5:0]};
        scored <= 1'b0;
      end else begin
        xPipe  <= xPipe - {5'd0, step};
      end
    end else if (score_inc) begin
      scored <= 1'b1;
    end
  end

  // saturating score counter
  always_ff @(posedge clk or negedge resetLow) begin
    if (!resetLow) begin
      score <= 8'd0;
    end else if (restart) begin
      score <= 8'd0;
    end else if (score_inc) begin
      score <= score_next;
    end
  end

`ifdef PIPE_SPEEDUP_EN
  logic [2:0] speed;
  logic       speed_up;

  // bump only on an actual increment that lands on a multiple of 8
  assign speed_up = score_inc && (score != 8'hFF) &&
                    (score_next[2:0] == 3'd0) && (speed < SPEED_MAX);

  // effective scroll speed, restored at reset and restart
  always_ff @(posedge clk or negedge resetLow) begin
    if (!resetLow) begin
      speed <= SPEED_V;
    end else if (restart) begin
      speed <= SPEED_V;
    end else if (speed_up) begin
      speed <= speed + 3'd1;
    end
  end

  assign step = speed;
`else
  assign step = SPEED_V;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Generates and scrolls the single on-screen pipe pair once per frame, and re-spawns it with a pseudo-random gap position.
- Drives the pipe-collision checker through xPipe/yPipe/height/width and a one-cycle evaluateCollision strobe, then samples its collisionHappen result.
- Tracks score and game-over state.
- Sits between the frame-rate tick generator, the collision checker and the VGA draw path.

Parameters:
- SCREEN_W, 160, horizontal screen size in pixels; pipe spawn x = SCREEN_W-1.
- PIPE_W, 12, pipe width driven on width; must be < 32.
- GAP_H, 40, vertical distance driven on height.
- Y_MIN, 8, minimum yPipe. Constraint: Y_MIN+63+GAP_H <= 119.
- SPEED, 1, pixels moved per frame; 1..4.
- Y_INIT, 40, yPipe after reset or restart.

Ports:
- clk, input, 1, system clock.
- resetLow, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse; begins play from IDLE or OVER.
- frameTick, input, 1, one-cycle pulse per frame.
- xBird, input, 8, bird x, used for scoring.
- collisionHappen, input, 1, sticky result from the collision checker.
- evaluateCollision, output, 1, one-cycle strobe to the checker.
- collisionClearLow, output, 1, active-low one-cycle clear; top level ANDs it into the checker's reset.
- xPipe, output, 8, pipe left edge.
- yPipe, output, 7, bottom edge of the top pipe (top of gap).
- height, output, 8, constant GAP_H.
- width, output, 5, constant PIPE_W.
- score, output, 8, pipes passed; saturates at 255.
- running, output, 1, high in MOVE/EVAL/CHECK.
- gameOver, output, 1, high in OVER.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-frame):
  - state=IDLE, xPipe=SCREEN_W-1, yPipe=Y_INIT, score=0, evaluateCollision=0, collisionClearLow=1, gameOver=0, running=0, scored flag=0, LFSR=8'hA5.
  - height=GAP_H and width=PIPE_W at all times.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clock in every state except under reset. Never reaches 0.
- States:
  - IDLE: wait for start. On start: collisionClearLow=0 for exactly that one cycle, then go to MOVE.
  - MOVE: wait for frameTick. On frameTick, in that same edge:
    - If xPipe < SPEED: xPipe <= SCREEN_W-1, yPipe <= Y_MIN + LFSR[5:0], scored <= 0 (respawn).
    - Else: xPipe <= xPipe - SPEED.
    - Next state EVAL.
  - EVAL: evaluateCollision=1 for exactly this one cycle, with the updated xPipe/yPipe stable. Next state CHECK.
  - CHECK: the checker has registered its result by now.
    - If collisionHappen=1: go to OVER.
    - Else: if scored=0 and xPipe+PIPE_W < xBird (9-bit compare), then score <= min(score+1, 255) and scored <= 1. Go to MOVE.
  - OVER: gameOver=1 and outputs frozen. On start: restore the reset values of xPipe, yPipe and score (LFSR keeps running), pulse collisionClearLow low for one cycle, go to MOVE.
- Latency: frameTick to evaluateCollision = 1 cycle; to the score/over decision = 2 cycles.
- A frameTick arriving in IDLE, EVAL, CHECK or OVER is dropped; it is not queued.
- start in MOVE, EVAL or CHECK is ignored.
- start and frameTick in the same cycle from IDLE: start wins; that tick is dropped.
- xPipe never wraps through 0: a position below SPEED always respawns.
- Score increments at most once per pipe pass.

Optional Feature:
- Macro: PIPE_SPEEDUP_EN.
- Defined: the effective speed register starts at SPEED. It increments by 1, capped at 4, each time score crosses a multiple of 8 (8, 16, 24, ...). The respawn test uses the effective speed. Speed returns to SPEED on reset or restart.
- Undefined: speed is constant SPEED; no extra register.

Test Plan:
- Reset then start, with 3 frameTicks (SPEED=1) -> xPipe goes 159, 158, 157, 156. evaluateCollision is high exactly 1 cycle after each tick. collisionClearLow is low for 1 cycle at start.
- Force xPipe=0 via ticks, with LFSR state known -> next tick gives xPipe=159 and yPipe=8+LFSR[5:0]. A yPipe of 72 must never occur; 8..71 only.
- xBird=60, no collision, pipe scrolled from 159 to 47 -> score increments to 1 in the CHECK cycle where xPipe+12<60 first holds. It stays 1 until respawn.
- collisionHappen=1 asserted by the model at the EVAL edge -> OVER next cycle, gameOver=1. Further ticks leave xPipe unchanged. start -> xPipe=159, score=0, clear pulse issued.
- resetLow low for 1 ns mid-EVAL -> all outputs take reset values immediately, with no waiting for clk. evaluateCollision drops asynchronously.
- With PIPE_SPEEDUP_EN: at score 8 the next tick moves xPipe by 2. At score 24 and beyond, the step stays capped at 4.
